// File: rtl/movement_pkg.sv
// Shared definitions for the movement command path: movement codes (also used
// by the motor-side decoder), ASCII command letters and receiver state encoding.
package movement_pkg;

    typedef logic [3:0] mov_code_t;

    localparam mov_code_t MOV_STOP     = 4'h0;
    localparam mov_code_t MOV_FORWARD  = 4'h1;
    localparam mov_code_t MOV_BACKWARD = 4'h2;
    localparam mov_code_t MOV_LEFT     = 4'h3;
    localparam mov_code_t MOV_RIGHT    = 4'h4;
    localparam mov_code_t MOV_ROT_CW   = 4'h5;
    localparam mov_code_t MOV_ROT_CCW  = 4'h6;

    // Upper-case command letters; lower-case differs only in bit 5.
    localparam logic [7:0] ASCII_S  = 8'h53;
    localparam logic [7:0] ASCII_F  = 8'h46;
    localparam logic [7:0] ASCII_B  = 8'h42;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_C  = 8'h43;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] CASE_BIT = 8'h20;

    // Depth of the rx metastability synchroniser.
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic      hit;
        mov_code_t code;
    } decode_t;

    // Map a received byte to a movement code; hit=0 for anything that is
    // not a command letter in either case.
    function automatic decode_t decode_cmd(input logic [7:0] b);
        decode_t d;
        d.hit  = 1'b1;
        d.code = MOV_STOP;
        case (b)
            ASCII_S, ASCII_S | CASE_BIT: d.code = MOV_STOP;
            ASCII_F, ASCII_F | CASE_BIT: d.code = MOV_FORWARD;
            ASCII_B, ASCII_B | CASE_BIT: d.code = MOV_BACKWARD;
            ASCII_L, ASCII_L | CASE_BIT: d.code = MOV_LEFT;
            ASCII_R, ASCII_R | CASE_BIT: d.code = MOV_RIGHT;
            ASCII_C, ASCII_C | CASE_BIT: d.code = MOV_ROT_CW;
            ASCII_W, ASCII_W | CASE_BIT: d.code = MOV_ROT_CCW;
            default:                     d.hit  = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/movement_command_rx_if.sv
// Serial input and movement outputs of the command receiver.
// master: the side driving rx (link / test side); slave: the receiver itself.
interface movement_command_rx_if;
    import movement_pkg::*;

    logic      rx;
    mov_code_t movement_sel;
    logic      cmd_valid;
    logic      frame_err;
    logic      link_active;

    modport master (
        output rx,
        input  movement_sel,
        input  cmd_valid,
        input  frame_err,
        input  link_active
    );

    modport slave (
        input  rx,
        output movement_sel,
        output cmd_valid,
        output frame_err,
        output link_active
    );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchroniser, bit-period counter, receive FSM and
// LSB-first shift register. data_valid / frame_err are registered 1-cycle pulses.
module uart_rx_core
    import movement_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_sync;
    logic                   rx_prev_reg;

    rx_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2:0]             bit_idx_reg, bit_idx_next;
    logic [7:0]             shift_reg, shift_next;
    logic                   brk_reg, brk_next;
    logic                   data_valid_reg, data_valid_next;
    logic                   frame_err_reg, frame_err_next;

    assign rx_sync = sync_reg[SYNC_STAGES-1];

    // Synchroniser chain plus one extra stage for falling-edge detection;
    // everything resets to the idle-high level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg    <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], rx};
            rx_prev_reg <= rx_sync;
        end
    end

    // Receiver state register; reset drops any partially received byte.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= RX_IDLE;
            cnt_reg        <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            brk_reg        <= 1'b0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_idx_reg    <= bit_idx_next;
            shift_reg      <= shift_next;
            brk_reg        <= brk_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Next-state logic: centre-sample the start bit, then sample each data
    // bit and the stop bit one full bit period apart.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_idx_next    = bit_idx_reg;
        shift_next      = shift_reg;
        brk_next        = brk_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;

        case (state_reg)
            RX_IDLE: begin
                if (rx_prev_reg && !rx_sync) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end

            RX_START: begin
                if (cnt_reg == CNT_HALF) begin
                    if (!rx_sync) begin
                        state_next   = RX_DATA;
                        cnt_next     = '0;
                        bit_idx_next = '0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_next = RX_IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RX_DATA: begin
                if (cnt_reg == CNT_FULL) begin
                    shift_next   = {rx_sync, shift_reg[7:1]};
                    cnt_next     = '0;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RX_STOP: begin
                if (brk_reg) begin
                    // Bad stop bit seen: hold here until the line returns
                    // high so a break is not mistaken for a new start bit.
                    if (rx_sync) begin
                        brk_next   = 1'b0;
                        state_next = RX_IDLE;
                    end
                end else if (cnt_reg == CNT_FULL) begin
                    cnt_next = '0;
                    if (rx_sync) begin
                        data_valid_next = 1'b1;
                        state_next      = RX_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        brk_next       = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            default: state_next = RX_IDLE;
        endcase
    end

    assign data       = shift_reg;
    assign data_valid = data_valid_reg;
    assign frame_err  = frame_err_reg;

endmodule

// File: rtl/movement_command_rx.sv
// Bluetooth command front end: UART receiver, command-letter decode and a
// link watchdog that forces STOP when valid commands stop arriving.
module movement_command_rx
    import movement_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 5208,
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic                 clk,
    input  logic                 rst,
    movement_command_rx_if.slave bus
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    decode_t    cmd;
    logic       accept;

    mov_code_t  movement_sel_reg;
    logic       cmd_valid_reg;
    logic       frame_err_reg;
    logic       link_active_reg;
    logic [WD_W-1:0] wd_cnt_reg;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_core (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus.rx),
        .data       (rx_data),
        .data_valid (rx_valid),
        .frame_err  (rx_ferr)
    );

    assign cmd    = decode_cmd(rx_data);
    assign accept = rx_valid && cmd.hit;

    // Command latch and watchdog. A command arriving on the expiry cycle
    // takes priority, so the link never drops while commands keep coming.
    always_ff @(posedge clk) begin
        if (!rst) begin
            movement_sel_reg <= MOV_STOP;
            cmd_valid_reg    <= 1'b0;
            frame_err_reg    <= 1'b0;
            link_active_reg  <= 1'b0;
            wd_cnt_reg       <= '0;
        end else begin
            cmd_valid_reg <= accept;
            frame_err_reg <= rx_ferr;
            if (accept) begin
                movement_sel_reg <= cmd.code;
                link_active_reg  <= 1'b1;
                wd_cnt_reg       <= '0;
            end else if (link_active_reg) begin
                if (wd_cnt_reg == WD_LAST) begin
                    movement_sel_reg <= MOV_STOP;
                    link_active_reg  <= 1'b0;
                end else begin
                    wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
                end
            end
        end
    end

    assign bus.movement_sel = movement_sel_reg;
    assign bus.cmd_valid    = cmd_valid_reg;
    assign bus.frame_err    = frame_err_reg;
    assign bus.link_active  = link_active_reg;

endmodule

// File: tb/tb_movement_command_rx.sv
// Bench for movement_command_rx: directed vector table, hand-written
// reset / glitch / watchdog / coincidence sequences, then random bursts
// checked against a letter-lookup reference model.
module tb_movement_command_rx;

    localparam int CPB = 8;
    localparam int TMO = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    movement_command_rx_if bus ();

    movement_command_rx #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Pulse monitor, sampled mid-cycle.
    int cv_count = 0, fe_count = 0, overlap_count = 0, last_cv = -1;
    always @(negedge clk) begin
        if (bus.cmd_valid) begin
            cv_count <= cv_count + 1;
            last_cv  <= cycle;
        end
        if (bus.frame_err) fe_count <= fe_count + 1;
        if (bus.cmd_valid && bus.frame_err) overlap_count <= overlap_count + 1;
    end

    int vectors = 0, miscompares = 0;
    int last_start = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference decode: position of the letter in the command list, either case.
    function automatic void ref_decode(input logic [7:0] b, output bit hit, output logic [3:0] code);
        string letters = "SFBLRCW";
        hit  = 1'b0;
        code = 4'h0;
        for (int i = 0; i < letters.len(); i++) begin
            if (b == letters[i] || b == (letters[i] | 8'h20)) begin
                hit  = 1'b1;
                code = 4'(i);
            end
        end
    endfunction

    // All stimulus moves on negedges; each call starts and ends on a negedge.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        last_start = cycle;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = stop_val;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_cv;
        int         exp_fe;
        logic [3:0] exp_sel;
        logic       exp_link;
    } vec_t;
    vec_t vecs[11];

    task automatic apply_vec(input int i);
        int cv0, fe0;
        cv0 = cv_count;
        fe0 = fe_count;
        send_frame(vecs[i].b, vecs[i].stop);
        idle(6);
        $display("vec %0d: byte 0x%02h stop %0b -> sel %0h link %0b pulses %0d ferr %0d",
                 i, vecs[i].b, vecs[i].stop, bus.movement_sel, bus.link_active,
                 cv_count - cv0, fe_count - fe0);
        check($sformatf("vec%0d_cmd_valid", i), cv_count - cv0, vecs[i].exp_cv);
        check($sformatf("vec%0d_frame_err", i), fe_count - fe0, vecs[i].exp_fe);
        check($sformatf("vec%0d_sel", i), int'(bus.movement_sel), int'(vecs[i].exp_sel));
        check($sformatf("vec%0d_link", i), int'(bus.link_active), int'(vecs[i].exp_link));
    endtask

    initial begin
        #5000000;
        $display("FAIL global_time_limit: got still running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int cv0, fe0, n, d;
        logic [7:0] w;
        logic [3:0] exp_sel;
        logic       exp_link;
        int         last_hit_end;

        vecs[0]  = '{8'h46, 1'b1, 1, 0, 4'h1, 1'b1};  // 'F'
        vecs[1]  = '{8'h72, 1'b1, 1, 0, 4'h4, 1'b1};  // 'r'
        vecs[2]  = '{8'h0D, 1'b1, 0, 0, 4'h4, 1'b1};  // CR ignored
        vecs[3]  = '{8'h31, 1'b1, 0, 0, 4'h4, 1'b1};  // '1' ignored
        vecs[4]  = '{8'h42, 1'b0, 0, 1, 4'h0, 1'b0};  // 'B' bad stop, after expiry
        vecs[5]  = '{8'h42, 1'b1, 1, 0, 4'h2, 1'b1};  // 'B'
        vecs[6]  = '{8'h63, 1'b1, 1, 0, 4'h5, 1'b1};  // 'c'
        vecs[7]  = '{8'h53, 1'b1, 1, 0, 4'h0, 1'b1};  // 'S'
        vecs[8]  = '{8'h77, 1'b1, 1, 0, 4'h6, 1'b1};  // 'w'
        vecs[9]  = '{8'h43, 1'b1, 1, 0, 4'h5, 1'b1};  // 'C'
        vecs[10] = '{8'h57, 1'b1, 1, 0, 4'h6, 1'b1};  // 'W' after mid-frame reset

        // Reset hold, with a full 'F' frame sent while in reset.
        rst = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_sel", int'(bus.movement_sel), 0);
        check("reset_link", int'(bus.link_active), 0);
        check("reset_cmd_valid", int'(bus.cmd_valid), 0);
        check("reset_frame_err", int'(bus.frame_err), 0);
        send_frame(8'h46, 1'b1);
        idle(4);
        $display("frame during reset: sel %0h link %0b pulses %0d", bus.movement_sel, bus.link_active, cv_count);
        check("reset_frame_sel", int'(bus.movement_sel), 0);
        check("reset_frame_pulses", cv_count + fe_count, 0);
        check("reset_frame_link", int'(bus.link_active), 0);
        rst = 1'b1;
        idle(10);

        for (int i = 0; i < 4; i++) apply_vec(i);

        // Watchdog: link drops exactly TMO cycles after the 'r' pulse.
        n = last_cv;
        cv0 = cv_count;
        while (cycle < n + TMO - 1) @(negedge clk);
        check("wd_link_before", int'(bus.link_active), 1);
        check("wd_sel_before", int'(bus.movement_sel), 4);
        @(negedge clk);
        $display("watchdog at cmd+%0d: sel %0h link %0b", cycle - n, bus.movement_sel, bus.link_active);
        check("wd_link_after", int'(bus.link_active), 0);
        check("wd_sel_after", int'(bus.movement_sel), 0);
        idle(4);
        check("wd_no_cmd_valid", cv_count - cv0, 0);

        for (int i = 4; i < 9; i++) apply_vec(i);

        // Two-cycle low glitch while idle must not produce anything.
        cv0 = cv_count;
        fe0 = fe_count;
        bus.rx = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        $display("glitch: sel %0h pulses %0d ferr %0d", bus.movement_sel, cv_count - cv0, fe_count - fe0);
        check("glitch_cmd_valid", cv_count - cv0, 0);
        check("glitch_frame_err", fe_count - fe0, 0);
        check("glitch_sel", int'(bus.movement_sel), 6);

        // 'C', then reset in the middle of a 'W' frame.
        apply_vec(9);
        w = 8'h57;
        cv0 = cv_count;
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.rx = w[i];
            repeat (CPB) @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("mid-frame reset: sel %0h link %0b", bus.movement_sel, bus.link_active);
        check("midrst_sel", int'(bus.movement_sel), 0);
        check("midrst_link", int'(bus.link_active), 0);
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(30);
        check("midrst_no_cmd", cv_count - cv0, 0);
        apply_vec(10);

        // Land an 'L' command exactly on the watchdog expiry cycle.
        n = last_cv;
        d = last_cv - last_start;
        while (cycle < n + TMO - d) @(negedge clk);
        cv0 = cv_count;
        send_frame(8'h4C, 1'b1);
        idle(6);
        $display("coincident cmd: pulse at cmd+%0d sel %0h link %0b", last_cv - n, bus.movement_sel, bus.link_active);
        check("coin_cycle", last_cv, n + TMO);
        check("coin_cmd_valid", cv_count - cv0, 1);
        check("coin_sel", int'(bus.movement_sel), 3);
        check("coin_link", int'(bus.link_active), 1);

        // Random bursts of frames, some back-to-back, some with bad stop bits.
        exp_sel = 4'h3;
        exp_link = 1'b1;
        last_hit_end = cycle;
        for (int bst = 0; bst < 15; bst++) begin
            int nfr, exp_dcv, exp_dfe;
            bit burst_hit;
            nfr = $urandom_range(1, 4);
            exp_dcv = 0;
            exp_dfe = 0;
            burst_hit = 1'b0;
            cv0 = cv_count;
            fe0 = fe_count;
            for (int f = 0; f < nfr; f++) begin
                logic [7:0] b;
                bit stop_bad, hit;
                logic [3:0] code;
                string letters = "SFBLRCW";
                if ($urandom_range(0, 2) != 0) begin
                    b = letters[$urandom_range(0, 6)];
                    if ($urandom_range(0, 1) == 1) b = b | 8'h20;
                end else begin
                    b = 8'($urandom_range(0, 255));
                end
                stop_bad = ($urandom_range(0, 7) == 0);
                send_frame(b, !stop_bad);
                ref_decode(b, hit, code);
                if (stop_bad) begin
                    exp_dfe++;
                    idle(2 * CPB);
                end else begin
                    if (hit) begin
                        exp_sel = code;
                        exp_dcv++;
                        burst_hit = 1'b1;
                        last_hit_end = cycle;
                    end
                    if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 12));
                end
            end
            idle(6);
            if (burst_hit) begin
                exp_link = 1'b1;
            end else begin
                while (cycle < last_hit_end + TMO + 20) @(negedge clk);
                exp_sel = 4'h0;
                exp_link = 1'b0;
            end
            $display("burst %0d: %0d frames -> sel %0h link %0b pulses %0d ferr %0d",
                     bst, nfr, bus.movement_sel, bus.link_active, cv_count - cv0, fe_count - fe0);
            check($sformatf("rand%0d_cmd_valid", bst), cv_count - cv0, exp_dcv);
            check($sformatf("rand%0d_frame_err", bst), fe_count - fe0, exp_dfe);
            check($sformatf("rand%0d_sel", bst), int'(bus.movement_sel), int'(exp_sel));
            check($sformatf("rand%0d_link", bst), int'(bus.link_active), int'(exp_link));
        end

        check("pulse_overlap", overlap_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/movement_command_rx.md
Name: movement_command_rx

Overview:
- Serial command front end that produces the 4-bit movement_sel consumed by the motor control chain.
- Receives 8N1 UART bytes from the Bluetooth module and decodes ASCII command letters into movement codes.
- Holds each decoded code until the next valid command arrives.
- A link watchdog forces STOP when commands stop arriving.

Parameters:
- CLKS_PER_BIT, 5208: clock cycles per UART bit (50 MHz / 9600 baud); minimum 4.
- TIMEOUT_CYCLES, 25000000: cycles without a valid command before a forced STOP (0.5 s at 50 MHz); minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- rx  in  1  UART serial input; idle high; asynchronous to clk.
- movement_sel  out  4  current movement code.
- cmd_valid  out  1  one-cycle pulse when a recognised command updates movement_sel.
- frame_err  out  1  one-cycle pulse when a byte has a bad stop bit.
- link_active  out  1  high while the watchdog has not expired.

Behaviour:
- Reset (rst==0 at a clk edge):
  - movement_sel=4'h0 (STOP); cmd_valid=0; frame_err=0; link_active=0.
  - Receiver returns to IDLE; bit counter, shift register and watchdog counter cleared.
  - A reset mid-frame discards the partial byte.
- rx input: passes through a 2-FF synchroniser. All sampling uses the synchronised signal (2-cycle input latency).
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of synchronised rx, go to START and clear the bit-period counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), check rx.
    - rx==0: go to DATA and restart the counter.
    - rx==1: glitch; return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into an 8-bit shift register. After 8 samples go to STOP.
  - STOP: sample at the next full bit period.
    - rx==1: byte accepted.
    - rx==0: frame_err pulses for 1 cycle, byte discarded. FSM waits for rx==1 before returning to IDLE (no false start during a break).
- Decode of an accepted byte (upper- and lower-case both accepted):
  - 'S' (0x53/0x73) -> 4'h0 STOP
  - 'F' (0x46/0x66) -> 4'h1 FORWARD
  - 'B' (0x42/0x62) -> 4'h2 BACKWARD
  - 'L' (0x4C/0x6C) -> 4'h3 LEFT
  - 'R' (0x52/0x72) -> 4'h4 RIGHT
  - 'C' (0x43/0x63) -> 4'h5 ROTATE_CW
  - 'W' (0x57/0x77) -> 4'h6 ROTATE_CCW
  - Any other byte (CR, LF, digits, ...): ignored. No cmd_valid pulse, movement_sel unchanged, watchdog NOT reloaded.
- Latency of an update: movement_sel and cmd_valid update on the clk edge after the accepted stop-bit sample. cmd_valid pulses even if the new code equals the old one.
- Watchdog:
  - Counter reloads to 0 on every cmd_valid and sets link_active=1.
  - While link_active==1, the counter increments each cycle.
  - When it reaches TIMEOUT_CYCLES-1, the next cycle sets movement_sel=STOP and link_active=0. No cmd_valid pulse is generated for this.
  - Counter saturates while link_active==0.
- Simultaneous timeout and cmd_valid in the same cycle: the command wins (movement_sel=decoded code, link_active=1, counter=0).
- frame_err and cmd_valid are never high together.
- Back-to-back frames with no idle gap beyond the stop bit are received correctly.

Decomposition:
- Shared package movement_pkg:
  - movement code constants MOV_STOP..MOV_ROT_CCW (4-bit);
  - ASCII command constants;
  - receiver state encoding.
  - The motor-side decoder uses the same movement code constants.
- Sub-module uart_rx_core: synchroniser, FSM, bit counter, shift register. Outputs data[7:0], data_valid, frame_err.
- The top level contains the decode table and the watchdog.

Test Plan:
- Bench settings: CLKS_PER_BIT=8, TIMEOUT_CYCLES=400 for all scenarios.
- Reset hold, rx=1 -> movement_sel=0, link_active=0, all pulses 0. Drive 'F' (0x46) during rst=0 -> no change.
- Send 0x46 after reset -> one cmd_valid pulse, movement_sel=4'h1, link_active=1. Then send 0x72 ('r') -> movement_sel=4'h4.
- Send 0x0D, then 0x31 -> no cmd_valid, movement_sel holds 4'h4. Watchdog still expires 400 cycles after the 'r' pulse: movement_sel=0, link_active=0.
- Send 0x42 with the stop bit driven 0 -> frame_err pulse, movement_sel unchanged. Then hold rx=1 and send 0x42 -> movement_sel=4'h2.
- 2-cycle low glitch on rx during idle -> FSM returns to IDLE. No pulses on any output.
- Send 'C', then drop rst=0 mid-frame of a second 'W' -> movement_sel=0 next edge. After release, a clean 'W' -> movement_sel=4'h6. Also force a command to complete on the timeout cycle -> movement_sel=decoded code, link_active=1.
